// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg -- shared types and constants for the fifo write arbiter.
//   arbState_t   : arbiter state (ARB = free arbitration, LOCK = burst owned)
//   DEF_*        : default parameter values for fifo_wr_arbiter
//   COUNT_WIDTH  : width of the issued-beat counter (countOut)
package fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arbState_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_LEN  = 8;
  localparam int COUNT_WIDTH    = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin picker.
// Ports:
//   reqVec   [NUM_REQ-1:0] in  : eligible requests
//   ptr      [PTR_W-1:0]   in  : index of the last winner
//   grantVec [NUM_REQ-1:0] out : one-hot winner (zero when no request)
//   winIdx   [PTR_W-1:0]   out : binary index of the winner (0 when none)
// The scan starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grantVec,
  output logic [PTR_W-1:0]   winIdx
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grantVec = '0;
    winIdx   = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // ptr < NUM_REQ and k <= NUM_REQ, so one subtraction gives the modulo.
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && reqVec[idx]) begin
        found         = 1'b1;
        grantVec[idx] = 1'b1;
        winIdx        = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin arbiter feeding a single fifo write port.
// Ports:
//   clkIn        in  : clock, rising edge
//   rstIn        in  : asynchronous active-high reset
//   reqDataIn    in  : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   reqValidIn   in  : per-requester valid
//   reqReadyOut  out : per-requester accept (at most one high, combinational)
//   wrDataOut    out : registered write word, holds last value
//   wrValidOut   out : single-cycle write strobe, one cycle after an accept
//   wrReadyIn    in  : fifo has space (fifo must provide >= 2 entries of skid)
//   grantOut     out : registered one-hot owner of the current write beat
//   countOut     out : total beats issued, wraps at 16 bits
// Build option: define ARB_BURST_LOCK_EN to lock arbitration onto a winner
// for up to BURST_LEN beats. Without it arbitration is per-beat round-robin.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  output logic [DATA_WIDTH-1:0]         wrDataOut,
  output logic                          wrValidOut,
  input  logic                          wrReadyIn,
  output logic [NUM_REQ-1:0]            grantOut,
  output logic [COUNT_WIDTH-1:0]        countOut
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]          ptrReg;
  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     pickReq;
  logic [NUM_REQ-1:0]     pickGrant;
  logic [PW-1:0]          winIdx;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  selData;
  logic [DATA_WIDTH-1:0]  wrDataReg;
  logic                   wrValidReg;
  logic [NUM_REQ-1:0]     grantReg;
  logic [COUNT_WIDTH-1:0] countReg;

`ifdef ARB_BURST_LOCK_EN
  arbState_t     stateReg, stateNext;
  logic [PW-1:0] ownerReg, ownerNext;
  logic [7:0]    beatReg, beatNext;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      stateReg <= ARB;
      ownerReg <= '0;
      beatReg  <= '0;
    end else begin
      stateReg <= stateNext;
      ownerReg <= ownerNext;
      beatReg  <= beatNext;
    end
  end

  // Eligibility kept apart from next-state so the picker sees no feedback.
  always_comb begin
    eligible = reqValidIn;
    if (stateReg == LOCK) begin
      eligible = reqValidIn & (NUM_REQ'(1) << ownerReg);
    end
  end

  always_comb begin
    stateNext = stateReg;
    ownerNext = ownerReg;
    beatNext  = beatReg;
    case (stateReg)
      ARB: begin
        if (xfer) begin
          ownerNext = winIdx;
          if (BURST_LEN > 1) begin
            stateNext = LOCK;
            beatNext  = 8'd1;
          end
        end
      end
      LOCK: begin
        // Owner going idle frees the bus even if the fifo is stalled.
        if (!reqValidIn[ownerReg]) begin
          stateNext = ARB;
          beatNext  = '0;
        end else if (xfer) begin
          beatNext = beatReg + 8'd1;
          if (beatNext == 8'(BURST_LEN)) begin
            stateNext = ARB;
            beatNext  = '0;
          end
        end
      end
      default: begin
        stateNext = ARB;
        beatNext  = '0;
      end
    endcase
  end
`else
  assign eligible = reqValidIn;
  wire unusedBurstLen = (BURST_LEN > 0);
`endif

  // Nothing is accepted while the fifo is full or reset is asserted.
  assign pickReq = eligible & {NUM_REQ{wrReadyIn & ~rstIn}};

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) uPick (
    .reqVec   (pickReq),
    .ptr      (ptrReg),
    .grantVec (pickGrant),
    .winIdx   (winIdx)
  );

  assign reqReadyOut = pickGrant;
  assign xfer        = |pickGrant;

  // One-hot AND-OR data mux driven by the grant.
  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickGrant[i]) begin
        selData = selData | reqDataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      ptrReg     <= PW'(NUM_REQ - 1);
      wrDataReg  <= '0;
      wrValidReg <= 1'b0;
      grantReg   <= '0;
      countReg   <= '0;
    end else begin
      wrValidReg <= xfer;
      if (xfer) begin
        ptrReg    <= winIdx;
        wrDataReg <= selData;
        grantReg  <= pickGrant;
        countReg  <= countReg + COUNT_WIDTH'(1);
      end else begin
        grantReg <= '0;
      end
    end
  end

  assign wrDataOut  = wrDataReg;
  assign wrValidOut = wrValidReg;
  assign grantOut   = grantReg;
  assign countOut   = countReg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter -- directed and random checks of fifo_wr_arbiter against
// a behavioural round-robin / burst-lock model.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BL = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR*DW-1:0]   reqData;
  logic [NR-1:0]      reqValid;
  logic [NR-1:0]      reqReady;
  logic [DW-1:0]      wrData;
  logic               wrValid;
  logic               wrReady;
  logic [NR-1:0]      grant;
  logic [15:0]        count;

  int nAsserts = 0;
  int nFails   = 0;

  // Model state
  int          mLast;
  int          mCount;
  logic        mValid;
  logic [NR-1:0] mGrant;
  logic [DW-1:0] mData;
  bit          mLock;
  int          mOwner;
  int          mBeats;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clkIn       (clk),
    .rstIn       (rst),
    .reqDataIn   (reqData),
    .reqValidIn  (reqValid),
    .reqReadyOut (reqReady),
    .wrDataOut   (wrData),
    .wrValidOut  (wrValid),
    .wrReadyIn   (wrReady),
    .grantOut    (grant),
    .countOut    (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLast  = NR - 1;
    mCount = 0;
    mValid = 1'b0;
    mGrant = '0;
    mData  = '0;
    mLock  = 0;
    mOwner = 0;
    mBeats = 0;
  endtask

  // Winner per the rules: scan upward from last winner + 1; in a lock only
  // the owner counts; nothing while fifo full or in reset.
  function automatic int modelPick(input logic [NR-1:0] v, input logic wr, input logic r);
    int i;
    if (!wr || r) return -1;
    for (int k = 1; k <= NR; k++) begin
      i = (mLast + k) % NR;
      if (mLock && i != mOwner) continue;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelEdge(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input int w);
    if (w >= 0) begin
      mValid = 1'b1;
      mGrant = NR'(1) << w;
      mData  = d[w*DW +: DW];
      mCount = (mCount + 1) % 65536;
      mLast  = w;
    end else begin
      mValid = 1'b0;
      mGrant = '0;
    end
`ifdef ARB_BURST_LOCK_EN
    if (mLock && !v[mOwner]) begin
      mLock = 0;
    end else if (w >= 0) begin
      if (!mLock) begin
        mOwner = w;
        mBeats = 1;
        mLock  = (BL > 1);
      end else begin
        mBeats++;
        if (mBeats == BL) mLock = 0;
      end
    end
`else
    if (v == '1 && w == -2) mLock = 0;
`endif
  endtask

  // One clock cycle: drive, check accept, clock, check write port.
  task automatic doCycle(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic wr);
    int w;
    logic [NR-1:0] expReady;
    reqValid = v;
    reqData  = d;
    wrReady  = wr;
    #1;
    w = modelPick(v, wr, rst);
    expReady = '0;
    if (w >= 0) expReady[w] = 1'b1;
    check("reqReady", 32'(reqReady), 32'(expReady));
    @(posedge clk);
    #1;
    modelEdge(v, d, w);
    check("wrValid", 32'(wrValid), 32'(mValid));
    check("grant", 32'(grant), 32'(mGrant));
    check("wrData", wrData, mData);
    check("count", 32'(count), 32'(mCount));
    $display("cycle v=%b wr=%b ready=%b -> wrValid=%b grant=%b data=%h count=%0d",
             v, wr, reqReady, wrValid, grant, wrData, count);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    reqValid = '1;
    #1;
    check("rstReady", 32'(reqReady), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rstValid", 32'(wrValid), 32'd0);
    check("rstGrant", 32'(grant), 32'd0);
    check("rstData", wrData, 32'd0);
    check("rstCount", 32'(count), 32'd0);
    rst = 1'b0;
    modelReset();
    #1;
    check("postRstValid", 32'(wrValid), 32'd0);
  endtask

  function automatic logic [NR*DW-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [NR*DW-1:0] d;
    rst = 1'b1;
    reqValid = '0;
    reqData = '0;
    wrReady = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    applyReset();

    // All four valid, fifo ready: round robin (or bursts with lock).
    for (int c = 0; c < 8; c++) doCycle(4'b1111, rndData(), 1'b1);
    check("count8", 32'(count), 32'd8);

    // Requester 2 alone streams consecutive words.
    for (int c = 0; c < 3; c++) begin
      d = '0;
      d[2*DW +: DW] = 32'h100 + 32'(c);
      doCycle(4'b0100, d, 1'b1);
    end
    check("data102", wrData, 32'h102);

    // Fifo full for 5 cycles, then resume.
    for (int c = 0; c < 5; c++) doCycle(4'b1111, rndData(), 1'b0);
    for (int c = 0; c < 4; c++) doCycle(4'b1111, rndData(), 1'b1);

    // Two requesters always valid.
    applyReset();
    for (int c = 0; c < 10; c++) doCycle(4'b0011, rndData(), 1'b1);

    // Requester 0 drops after 2 beats.
    applyReset();
    doCycle(4'b0011, rndData(), 1'b1);
    doCycle(4'b0011, rndData(), 1'b1);
    for (int c = 0; c < 3; c++) doCycle(4'b0010, rndData(), 1'b1);
    check("dropGrant", 32'(grant), 32'd2);

    // Random traffic.
    for (int c = 0; c < 300; c++)
      doCycle(NR'($urandom), rndData(), ($urandom_range(0, 7) != 0));

    // Reset in the middle of a burst with five beats issued.
    applyReset();
    for (int c = 0; c < 5; c++) doCycle(4'b1111, rndData(), 1'b1);
    check("count5", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("midRstValid", 32'(wrValid), 32'd0);
    check("midRstGrant", 32'(grant), 32'd0);
    check("midRstData", wrData, 32'd0);
    check("midRstCount", 32'(count), 32'd0);
    check("midRstReady", 32'(reqReady), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    #1;
    check("relValid", 32'(wrValid), 32'd0);
    doCycle(4'b1111, rndData(), 1'b1);
    check("firstGrant", 32'(grant), 32'd1);
    doCycle(4'b1111, rndData(), 1'b1);

    // Counter wrap over 65536 transfers.
    applyReset();
    reqValid = 4'b0001;
    wrReady = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("countFFFF", 32'(count), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    check("countWrap", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
